dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 42 ++++
 rtl/dmem_rr_arb.sv | 38 +++
 rtl/dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the two-port data-memory arbiter:
//   - access-size encodings (OPT_BYTE / OPT_HALF / OPT_WORD, plus the illegal code)
//   - FSM state enum (IDLE, ACC, RSP)
//   - latched access bundle type
//   - alignment helper used when DMEM_ARB_ALIGN_CHK_EN is defined
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam logic [1:0] OPT_BYTE = 2'b00;
    localparam logic [1:0] OPT_HALF = 2'b01;
    localparam logic [1:0] OPT_ILL  = 2'b10;
    localparam logic [1:0] OPT_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        RSP  = 2'b10
    } state_t;

    // One memory access as captured at grant time
    typedef struct packed {
        logic        we;
        logic [1:0]  opt;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } acc_t;

    // True when the size code is illegal or the address is not naturally aligned
    function automatic logic is_misaligned(input logic [1:0] opt, input logic [5:0] addr);
        logic bad;
        case (opt)
            OPT_BYTE: bad = 1'b0;
            OPT_HALF: bad = addr[0];
            OPT_WORD: bad = (addr[1:0] != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// ---------------------------------------------------------------------------
// dmem_rr_arb
// Two-way round-robin grant with a last-grant pointer.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req0, req1    : requests from port 0 / port 1
//   en            : grant is being consumed this cycle (pointer may advance)
//   gnt0, gnt1    : one-hot (or zero) combinational grant
// After reset port 0 has priority.
// ---------------------------------------------------------------------------
module dmem_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic en,
    output logic gnt0,
    output logic gnt1
);

    // 1: port 1 was granted last, so port 0 wins a tie
    logic last1_r;

    assign gnt0 = req0 & (~req1 | last1_r);
    assign gnt1 = req1 & (~req0 | ~last1_r);

    // Last-grant pointer; only moves when a grant is actually taken
    always_ff @(posedge clk) begin
        if (rst) begin
            last1_r <= 1'b1;
        end else if (en && (gnt0 || gnt1)) begin
            last1_r <= gnt1;
        end else begin
            last1_r <= last1_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates two requesters onto a single-ported data memory.
// Each transaction: IDLE (grant) -> ACC (one memory cycle) -> RSP (hold
// response until the owner takes it) -> IDLE.
//
// Ports (N = 0, 1):
//   clk, rst                  : clock, synchronous active-high reset
//   pN_req_valid/pN_req_ready : request handshake (ready is combinational)
//   pN_we, pN_opt, pN_addr, pN_wdata : access description
//   pN_rsp_valid/pN_rsp_ready : response handshake
//   pN_rdata, pN_rsp_err      : response payload
//   dm_e, dm_r, dm_w, dm_opt, dm_addr, dm_wdata : memory request (ACC only)
//   dm_rdata                  : memory read data, sampled only in ACC
//   busy                      : FSM not in IDLE
//
// Configuration macro: DMEM_ARB_ALIGN_CHK_EN
//   defined   : illegal size / misaligned accesses skip ACC and answer err=1
//   undefined : every request is forwarded unchanged, err is always 0
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic        p0_we,
    input  logic [1:0]  p0_opt,
    input  logic [5:0]  p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_rsp_valid,
    input  logic        p0_rsp_ready,
    output logic [31:0] p0_rdata,
    output logic        p0_rsp_err,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic        p1_we,
    input  logic [1:0]  p1_opt,
    input  logic [5:0]  p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_rsp_valid,
    input  logic        p1_rsp_ready,
    output logic [31:0] p1_rdata,
    output logic        p1_rsp_err,

    output logic        dm_e,
    output logic        dm_r,
    output logic        dm_w,
    output logic [1:0]  dm_opt,
    output logic [5:0]  dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,

    output logic        busy
);

    state_t      state_r;
    state_t      state_nxt_s;

    logic        gnt0_s;
    logic        gnt1_s;
    logic        grant_ok_s;
    logic        load_s;
    logic        misalign_s;
    logic        owner_ready_s;
    acc_t        sel_s;

    // acc_r is non-zero only during the ACC cycle, so it feeds dm_* directly
    acc_t        acc_r;
    logic        dm_e_r;
    logic        owner_r;
    logic        busy_r;

    logic        rsp_set_s;
    logic        rsp_port_s;
    logic [31:0] rsp_rdata_s;
    logic        rsp_err_s;
    logic        rsp_clr_s;

    logic        p0_rsp_valid_r;
    logic [31:0] p0_rdata_r;
    logic        p0_err_r;
    logic        p1_rsp_valid_r;
    logic [31:0] p1_rdata_r;
    logic        p1_err_r;

    // Grants are only honoured in IDLE and never on a reset edge
    assign grant_ok_s = (state_r == IDLE) && !rst;

    dmem_rr_arb u_rr_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (p0_req_valid),
        .req1 (p1_req_valid),
        .en   (grant_ok_s),
        .gnt0 (gnt0_s),
        .gnt1 (gnt1_s)
    );

    assign p0_req_ready  = gnt0_s & grant_ok_s;
    assign p1_req_ready  = gnt1_s & grant_ok_s;
    assign owner_ready_s = owner_r ? p1_rsp_ready : p0_rsp_ready;

    // Select the winning requester's access fields
    always_comb begin
        sel_s = '0;
        if (gnt1_s) begin
            sel_s.we    = p1_we;
            sel_s.opt   = p1_opt;
            sel_s.addr  = p1_addr;
            sel_s.wdata = p1_wdata;
        end else begin
            sel_s.we    = p0_we;
            sel_s.opt   = p0_opt;
            sel_s.addr  = p0_addr;
            sel_s.wdata = p0_wdata;
        end
    end

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign misalign_s = is_misaligned(sel_s.opt, sel_s.addr);
`else
    assign misalign_s = 1'b0;
`endif

    // FSM next-state and grant-load decode
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (p0_req_ready || p1_req_ready) begin
                    load_s      = 1'b1;
                    state_nxt_s = misalign_s ? RSP : ACC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACC: begin
                state_nxt_s = RSP;
            end
            RSP: begin
                if (owner_ready_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RSP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Response register update decode: fill at end of ACC or on a rejected grant
    always_comb begin
        rsp_set_s   = 1'b0;
        rsp_port_s  = owner_r;
        rsp_rdata_s = 32'h0000_0000;
        rsp_err_s   = 1'b0;
        rsp_clr_s   = 1'b0;
        if (state_r == ACC) begin
            rsp_set_s   = 1'b1;
            rsp_rdata_s = acc_r.we ? 32'h0000_0000 : dm_rdata;
        end else if (load_s && misalign_s) begin
            rsp_set_s  = 1'b1;
            rsp_port_s = gnt1_s;
            rsp_err_s  = 1'b1;
        end else if ((state_r == RSP) && owner_ready_s) begin
            rsp_clr_s = 1'b1;
        end else begin
            rsp_set_s = 1'b0;
        end
    end

    // Access latch, memory enable and owner capture
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= '0;
            dm_e_r  <= 1'b0;
            owner_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            if (load_s && !misalign_s) begin
                acc_r  <= sel_s;
                dm_e_r <= 1'b1;
            end else begin
                acc_r  <= '0;
                dm_e_r <= 1'b0;
            end
            if (load_s) begin
                owner_r <= gnt1_s;
            end else begin
                owner_r <= owner_r;
            end
            busy_r <= (state_nxt_s != IDLE);
        end
    end

    // Port 0 response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rsp_valid_r <= 1'b0;
            p0_rdata_r     <= 32'h0000_0000;
            p0_err_r       <= 1'b0;
        end else if (rsp_set_s && !rsp_port_s) begin
            p0_rsp_valid_r <= 1'b1;
            p0_rdata_r     <= rsp_rdata_s;
            p0_err_r       <= rsp_err_s;
        end else if (rsp_clr_s) begin
            p0_rsp_valid_r <= 1'b0;
            p0_rdata_r     <= 32'h0000_0000;
            p0_err_r       <= 1'b0;
        end else begin
            p0_rsp_valid_r <= p0_rsp_valid_r;
            p0_rdata_r     <= p0_rdata_r;
            p0_err_r       <= p0_err_r;
        end
    end

    // Port 1 response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_rsp_valid_r <= 1'b0;
            p1_rdata_r     <= 32'h0000_0000;
            p1_err_r       <= 1'b0;
        end else if (rsp_set_s && rsp_port_s) begin
            p1_rsp_valid_r <= 1'b1;
            p1_rdata_r     <= rsp_rdata_s;
            p1_err_r       <= rsp_err_s;
        end else if (rsp_clr_s) begin
            p1_rsp_valid_r <= 1'b0;
            p1_rdata_r     <= 32'h0000_0000;
            p1_err_r       <= 1'b0;
        end else begin
            p1_rsp_valid_r <= p1_rsp_valid_r;
            p1_rdata_r     <= p1_rdata_r;
            p1_err_r       <= p1_err_r;
        end
    end

    assign p0_rsp_valid = p0_rsp_valid_r;
    assign p0_rdata     = p0_rdata_r;
    assign p0_rsp_err   = p0_err_r;
    assign p1_rsp_valid = p1_rsp_valid_r;
    assign p1_rdata     = p1_rdata_r;
    assign p1_rsp_err   = p1_err_r;

    // Strobes are masked by rst so a write whose closing edge is a reset edge
    // never reaches the memory.
    assign dm_e     = dm_e_r & ~rst;
    assign dm_r     = dm_e_r & ~acc_r.we & ~rst;
    assign dm_w     = dm_e_r & acc_r.we & ~rst;
    assign dm_opt   = acc_r.opt;
    assign dm_addr  = acc_r.addr;
    assign dm_wdata = acc_r.wdata;

    assign busy     = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Table-driven bench for dmem_arbiter with a small byte-addressed memory
// model on the dm_* side, plus hand-written sequences for response
// back-pressure, reset abort and round-robin order from reset.
// Expectations for the alignment vectors follow DMEM_ARB_ALIGN_CHK_EN.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req_valid, p0_req_ready, p0_we, p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
    logic [1:0]  p0_opt;
    logic [5:0]  p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_req_valid, p1_req_ready, p1_we, p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
    logic [1:0]  p1_opt;
    logic [5:0]  p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic        dm_e, dm_r, dm_w, busy;
    logic [1:0]  dm_opt;
    logic [5:0]  dm_addr;
    logic [31:0] dm_wdata, dm_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
        .p0_opt(p0_opt), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
        .p0_rdata(p0_rdata), .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
        .p1_opt(p1_opt), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
        .p1_rdata(p1_rdata), .p1_rsp_err(p1_rsp_err),
        .dm_e(dm_e), .dm_r(dm_r), .dm_w(dm_w), .dm_opt(dm_opt),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .busy(busy)
    );

    // ---------------- memory model (little-endian, zero-extending) ----------
    logic [7:0]  mem [64];
    logic [5:0]  a1, a2, a3;
    logic [31:0] rd_word;

    initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    assign a1 = dm_addr + 6'd1;
    assign a2 = dm_addr + 6'd2;
    assign a3 = dm_addr + 6'd3;

    always @(posedge clk) begin
        if (dm_e && dm_w) begin
            mem[dm_addr] <= dm_wdata[7:0];
            if (dm_opt != 2'b00) mem[a1] <= dm_wdata[15:8];
            if (dm_opt == 2'b11) begin
                mem[a2] <= dm_wdata[23:16];
                mem[a3] <= dm_wdata[31:24];
            end
        end
    end

    always_comb begin
        rd_word = 32'h0;
        case (dm_opt)
            2'b00:   rd_word = {24'h0, mem[dm_addr]};
            2'b01:   rd_word = {16'h0, mem[a1], mem[dm_addr]};
            default: rd_word = {mem[a3], mem[a2], mem[a1], mem[dm_addr]};
        endcase
    end

    // Undriven bus stands in as a recognisable junk pattern
    assign dm_rdata = (dm_e && dm_r) ? rd_word : 32'hA5A5_A5A5;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v0;  logic we0; logic [1:0] o0; logic [5:0] a0; logic [31:0] d0;
        logic        v1;  logic we1; logic [1:0] o1; logic [5:0] a1; logic [31:0] d1;
        logic        own; logic [31:0] rdata; logic err;
    } vec_t;

    // One complete transaction: request, ACC, RSP, handshake back to IDLE
    task automatic run_txn(input vec_t v);
        logic       ewe;
        logic [1:0] eo;
        logic [5:0] ea;
        logic [31:0] ed;
        ewe = v.own ? v.we1 : v.we0;
        eo  = v.own ? v.o1  : v.o0;
        ea  = v.own ? v.a1  : v.a0;
        ed  = v.own ? v.d1  : v.d0;
        @(negedge clk);
        p0_req_valid = v.v0; p0_we = v.we0; p0_opt = v.o0; p0_addr = v.a0; p0_wdata = v.d0;
        p1_req_valid = v.v1; p1_we = v.we1; p1_opt = v.o1; p1_addr = v.a1; p1_wdata = v.d1;
        #1;
        chk("req_ready0", p0_req_ready, !v.own);
        chk("req_ready1", p1_req_ready, v.own);
        @(posedge clk); #1;
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        @(negedge clk);
        if (v.err) begin
            chk("err_no_dm_e", dm_e, 1'b0);
        end else begin
            chk("acc_dm_e", dm_e, 1'b1);
            chk("acc_dm_w", dm_w, ewe);
            chk("acc_dm_r", dm_r, !ewe);
            chk("acc_dm_addr", dm_addr, ea);
            chk("acc_dm_opt", dm_opt, eo);
            chk("acc_dm_wdata", dm_wdata, ed);
            chk("acc_busy", busy, 1'b1);
            chk("acc_no_rsp", p0_rsp_valid | p1_rsp_valid, 1'b0);
            @(negedge clk);
            chk("rsp_dm_e", dm_e, 1'b0);
            chk("rsp_dm_addr", dm_addr, 6'd0);
        end
        chk("rsp_valid_own", v.own ? p1_rsp_valid : p0_rsp_valid, 1'b1);
        chk("rsp_valid_other", v.own ? p0_rsp_valid : p1_rsp_valid, 1'b0);
        chk("rsp_rdata", v.own ? p1_rdata : p0_rdata, v.rdata);
        chk("rsp_err", v.own ? p1_rsp_err : p0_rsp_err, v.err);
        if (v.own) p1_rsp_ready = 1'b1; else p0_rsp_ready = 1'b1;
        @(posedge clk); #1;
        p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b0;
        @(negedge clk);
        chk("done_busy", busy, 1'b0);
        chk("done_rsp", p0_rsp_valid | p1_rsp_valid, 1'b0);
    endtask

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b11;
    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        //           v0   we0   o0  a0     d0              v1   we1   o1  a1     d1              own  rdata           err
        vecs[0]  = '{1'b1,1'b1, W, 6'h04, 32'h1122_3344, 1'b0,1'b0, B, 6'h00, 32'h0,         1'b0,32'h0,          1'b0};
        vecs[1]  = '{1'b1,1'b0, W, 6'h04, 32'h0,         1'b0,1'b0, B, 6'h00, 32'h0,         1'b0,32'h1122_3344,  1'b0};
        vecs[2]  = '{1'b0,1'b0, B, 6'h00, 32'h0,         1'b1,1'b1, B, 6'h05, 32'h0000_00AB, 1'b1,32'h0,          1'b0};
        vecs[3]  = '{1'b1,1'b0, H, 6'h04, 32'h0,         1'b0,1'b0, B, 6'h00, 32'h0,         1'b0,32'h0000_AB44,  1'b0};
        vecs[4]  = '{1'b1,1'b0, B, 6'h06, 32'h0,         1'b1,1'b0, B, 6'h07, 32'h0,         1'b1,32'h0000_0011,  1'b0};
        vecs[5]  = '{1'b1,1'b0, B, 6'h06, 32'h0,         1'b1,1'b0, B, 6'h07, 32'h0,         1'b0,32'h0000_0022,  1'b0};
        vecs[6]  = '{1'b0,1'b0, B, 6'h00, 32'h0,         1'b1,1'b1, W, 6'h08, 32'hDEAD_BEEF, 1'b1,32'h0,          1'b0};
        vecs[7]  = '{1'b1,1'b0, W, 6'h08, 32'h0,         1'b0,1'b0, B, 6'h00, 32'h0,         1'b0,32'hDEAD_BEEF,  1'b0};
        vecs[8]  = '{1'b0,1'b0, B, 6'h00, 32'h0,         1'b1,1'b0, H, 6'h0A, 32'h0,         1'b1,32'h0000_DEAD,  1'b0};
        vecs[9]  = '{1'b1,1'b0, B, 6'h0B, 32'h0,         1'b0,1'b0, B, 6'h00, 32'h0,         1'b0,32'h0000_00DE,  1'b0};
`ifdef DMEM_ARB_ALIGN_CHK_EN
        vecs[10] = '{1'b1,1'b0, W, 6'h02, 32'h0,         1'b0,1'b0, B, 6'h00, 32'h0,         1'b0,32'h0,          1'b1};
        vecs[11] = '{1'b0,1'b0, B, 6'h00, 32'h0,         1'b1,1'b0, H, 6'h03, 32'h0,         1'b1,32'h0,          1'b1};
`else
        vecs[10] = '{1'b1,1'b0, W, 6'h02, 32'h0,         1'b0,1'b0, B, 6'h00, 32'h0,         1'b0,32'hAB44_0000,  1'b0};
        vecs[11] = '{1'b0,1'b0, B, 6'h00, 32'h0,         1'b1,1'b0, H, 6'h03, 32'h0,         1'b1,32'h0000_4400,  1'b0};
`endif
        vecs[12] = '{1'b1,1'b1, H, 6'h0C, 32'h0000_5566, 1'b0,1'b0, B, 6'h00, 32'h0,         1'b0,32'h0,          1'b0};
        vecs[13] = '{1'b0,1'b0, B, 6'h00, 32'h0,         1'b1,1'b0, W, 6'h0C, 32'h0,         1'b1,32'h0000_5566,  1'b0};

        rst = 1'b1;
        p0_req_valid = 1'b0; p0_we = 1'b0; p0_opt = 2'b00; p0_addr = 6'h0; p0_wdata = 32'h0; p0_rsp_ready = 1'b0;
        p1_req_valid = 1'b0; p1_we = 1'b0; p1_opt = 2'b00; p1_addr = 6'h0; p1_wdata = 32'h0; p1_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dm_e", dm_e, 1'b0);
        chk("rst_dm_addr", dm_addr, 6'd0);
        chk("rst_rsp_valid", p0_rsp_valid | p1_rsp_valid, 1'b0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);
        chk("rst_err", p0_rsp_err | p1_rsp_err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_txn(vecs[i]);

        // Back-pressure: p1 read held for 5 cycles while p0 keeps requesting
        @(negedge clk);
        p1_req_valid = 1'b1; p1_we = 1'b0; p1_opt = W; p1_addr = 6'h04;
        @(posedge clk); #1;
        p1_req_valid = 1'b0;
        p0_req_valid = 1'b1; p0_we = 1'b0; p0_opt = B; p0_addr = 6'h06;
        @(negedge clk);
        chk("bp_acc_ready0", p0_req_ready, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid1", p1_rsp_valid, 1'b1);
            chk("bp_rdata1", p1_rdata, 32'h1122_AB44);
            chk("bp_ready0", p0_req_ready, 1'b0);
            chk("bp_valid0", p0_rsp_valid, 1'b0);
            chk("bp_busy", busy, 1'b1);
        end
        p0_req_valid = 1'b0;
        p1_rsp_ready = 1'b1;
        @(posedge clk); #1;
        p1_rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_done_busy", busy, 1'b0);
        chk("bp_done_valid1", p1_rsp_valid, 1'b0);

        // Reset during ACC of a write: transaction dropped, memory untouched
        @(negedge clk);
        p0_req_valid = 1'b1; p0_we = 1'b1; p0_opt = W; p0_addr = 6'h10; p0_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        p0_req_valid = 1'b0;
        @(negedge clk);
        chk("abort_pre_dm_w", dm_w, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_dm_w_masked", dm_w, 1'b0);
        chk("abort_dm_e_masked", dm_e, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_rsp_valid", p0_rsp_valid | p1_rsp_valid, 1'b0);
        chk("abort_dm_w", dm_w, 1'b0);
        chk("abort_rdata", p0_rdata, 32'h0);

        // Simultaneous requests from reset: order p0, p1, p0; memory still zero
        run_txn('{1'b1,1'b0, B, 6'h10, 32'h0, 1'b1,1'b0, B, 6'h11, 32'h0, 1'b0,32'h0,1'b0});
        run_txn('{1'b1,1'b0, B, 6'h10, 32'h0, 1'b1,1'b0, B, 6'h11, 32'h0, 1'b1,32'h0,1'b0});
        run_txn('{1'b1,1'b0, B, 6'h10, 32'h0, 1'b1,1'b0, B, 6'h11, 32'h0, 1'b0,32'h0,1'b0});
        run_txn('{1'b0,1'b0, B, 6'h00, 32'h0, 1'b1,1'b0, W, 6'h10, 32'h0, 1'b1,32'h0,1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on the whole run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
